leaf_out_rr_arbiter: RTL
========================

Name: leaf_out_rr_arbiter

Overview:
- Round-robin scheduler that shares one leaf-interface user input channel between NUM_IN_PORTS HLS kernel output streams (AXI-stream style TDATA/TVALID/TREADY).
- Sits in a page wrapper between the kernel's Output_n streams and the leaf interface.
- Each forwarded beat is tagged with its source port index.
- Grants are held for bursts of up to MAX_BURST beats to keep packets from one port contiguous.

Parameters:
- NUM_IN_PORTS, 2, number of requesting streams (1..2^NUM_PORT_BITS).
- PAYLOAD_BITS, 32, data width per beat.
- NUM_PORT_BITS, 4, width of the port tag.
- MAX_BURST, 16, maximum beats per grant (>=1).

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  synchronous reset, active-low.
- i_port_en  in  NUM_IN_PORTS  per-port enable mask. A masked port is never granted.
- i_data  in  NUM_IN_PORTS*PAYLOAD_BITS  concatenated input data, port 0 in the LSBs.
- i_valid  in  NUM_IN_PORTS  per-port valid.
- o_ready  out  NUM_IN_PORTS  per-port ready; at most one bit is high.
- o_data  out  PAYLOAD_BITS  registered output data.
- o_port  out  NUM_PORT_BITS  registered source port index of o_data.
- o_valid  out  1  registered output valid.
- i_ready  in  1  downstream ready.
- o_busy  out  1  high while the FSM is in GRANT.

Behaviour:
- Reset (ap_rst_n=0 at a clock edge):
  - Outputs: o_valid=0, o_data=0, o_port=0, o_ready=0, o_busy=0.
  - Internal: state=IDLE, rr_ptr=0, beat_cnt=0, gnt=0.
  - Reset mid-burst discards the output register content. No beat is replayed.
- Output register (one-entry slice):
  - slot_free = !o_valid || i_ready.
  - A load occurs when the granted port transfers. A load sets o_valid=1 and captures the data and tag (o_port=gnt).
  - If i_ready=1 and there is no load, o_valid clears.
  - o_data and o_port are held stable while o_valid=1 and i_ready=0.
- FSM IDLE:
  - o_ready=0.
  - Requests are req = i_valid & i_port_en.
  - If req != 0: gnt <= first set index at or after rr_ptr, wrapping modulo NUM_IN_PORTS. Also beat_cnt <= 0 and state <= GRANT.
  - Otherwise stay in IDLE.
- FSM GRANT:
  - o_ready[gnt] = slot_free && i_port_en[gnt]. All other o_ready bits are 0.
  - Transfer condition: i_valid[gnt] && o_ready[gnt]. On transfer, the output register loads and beat_cnt increments.
- Release from GRANT (state <= IDLE, rr_ptr <= (gnt+1) mod NUM_IN_PORTS) on any of:
  - a transfer that makes beat_cnt == MAX_BURST;
  - i_valid[gnt]=0 while slot_free=1 (early release; no transfer that cycle);
  - i_port_en[gnt]=0 (no transfer that cycle).
- Backpressure: i_valid[gnt]=0 while slot_free=0 does NOT release; the grant is kept.
- Latency and throughput:
  - Request seen in IDLE at cycle t → earliest transfer at cycle t+1 → o_valid at t+2.
  - Within a grant, 1 beat/cycle while i_ready=1.
  - One idle arbitration cycle occurs between grants.
- Fairness: with all ports continuously requesting, grants rotate 0,1,…,N-1,0,… with MAX_BURST beats each.
- NUM_IN_PORTS=1: rr_ptr stays 0, and bursts still break every MAX_BURST beats.
- No data loss or duplication: every i_valid&&o_ready handshake appears exactly once on o_valid&&i_ready, in order per port.
- o_busy = (state==GRANT).

Test Plan:
- Reset, then i_valid=2'b01, i_port_en=2'b11, i_ready=1, port0 data 0xA0..0xA2 then valid low:
  - o_valid first high 2 cycles after request;
  - o_port=0, o_data=0xA0,0xA1,0xA2 consecutive;
  - early release, rr_ptr=1.
- Both ports always valid, MAX_BURST=4, i_ready=1:
  - output tags 0,0,0,0,(gap),1,1,1,1,(gap),0…;
  - counted beats per port are equal over 80 cycles.
- Port1 streaming, i_ready held low 3 cycles mid-burst:
  - o_data and o_port held stable;
  - o_ready[1]=0 during the stall;
  - no beat lost or duplicated; beat sequence 0xB0..0xB7 intact.
- i_port_en=2'b10 with both ports valid: only o_port=1 appears. Deasserting en[1] mid-burst: o_ready[1]=0 the same cycle, FSM returns to IDLE, and no further grants occur.
- ap_rst_n pulsed low for 1 cycle mid-burst with o_valid=1 and i_ready=0:
  - next cycle o_valid=0, o_ready=0, o_busy=0;
  - after release the first grant goes to port 0 (rr_ptr reset).
- Random valid/ready/en stimulus for 10k cycles, checked against a scoreboard:
  - per-port in-order delivery;
  - onehot0(o_ready) every cycle;
  - no burst exceeds MAX_BURST beats.

Source files
------------

// File: rtl/leaf_out_rr_arbiter.sv
// leaf_out_rr_arbiter: round-robin burst arbiter that merges kernel
// output streams onto one tagged leaf-interface channel.
// Ports:
//   ap_clk, ap_rst_n      clock, synchronous active-low reset
//   i_port_en             per-port enable mask (masked ports never granted)
//   i_data/i_valid        concatenated per-port streams (port 0 in LSBs)
//   o_ready               per-port ready, at most one bit high
//   o_data/o_port/o_valid registered output beat and its source tag
//   i_ready               downstream ready
//   o_busy                high while a grant is held
module leaf_out_rr_arbiter #(
  parameter int NUM_IN_PORTS  = 2,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_PORT_BITS = 4,
  parameter int MAX_BURST     = 16
) (
  input  logic                                 ap_clk,
  input  logic                                 ap_rst_n,
  input  logic [NUM_IN_PORTS-1:0]              i_port_en,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] i_data,
  input  logic [NUM_IN_PORTS-1:0]              i_valid,
  output logic [NUM_IN_PORTS-1:0]              o_ready,
  output logic [PAYLOAD_BITS-1:0]              o_data,
  output logic [NUM_PORT_BITS-1:0]             o_port,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic                                 o_busy
);

  localparam int GW = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [GW-1:0]             gnt_q, gnt_d;
  logic [GW-1:0]             rr_q, rr_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [PAYLOAD_BITS-1:0]   data_q, data_d;
  logic [NUM_PORT_BITS-1:0]  port_q, port_d;
  logic                      vld_q, vld_d;

  logic [NUM_IN_PORTS-1:0]   req;
  logic [GW-1:0]             pick;
  logic [GW-1:0]             gnt_nxt;
  logic [31:0]               k;
  logic                      found;
  logic                      slot_free;
  logic                      sel_v;
  logic                      sel_en;
  logic [PAYLOAD_BITS-1:0]   sel_d;
  logic                      xfer;
  logic [CW-1:0]             cnt_inc;

  // First requester at or after rr_q, wrapping around the port count.
  always_comb begin
    req   = i_valid & i_port_en;
    pick  = rr_q;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      k = 32'(rr_q) + 32'(i);
      if (k >= 32'(NUM_IN_PORTS)) k = k - 32'(NUM_IN_PORTS);
      if (!found && req[k[GW-1:0]]) begin
        found = 1'b1;
        pick  = k[GW-1:0];
      end
    end
  end

  always_comb begin
    sel_v  = 1'b0;
    sel_en = 1'b0;
    sel_d  = '0;
    for (int p = 0; p < NUM_IN_PORTS; p++) begin
      if (gnt_q == GW'(p)) begin
        sel_v  = i_valid[p];
        sel_en = i_port_en[p];
        sel_d  = i_data[p*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  assign slot_free = !vld_q || i_ready;
  assign xfer      = (state_q == GRANT) && sel_v && sel_en && slot_free;
  assign cnt_inc   = cnt_q + 1'b1;
  assign gnt_nxt   = (gnt_q == GW'(NUM_IN_PORTS - 1)) ? '0 : gnt_q + 1'b1;

  always_comb begin
    o_ready = '0;
    for (int p = 0; p < NUM_IN_PORTS; p++) begin
      if (state_q == GRANT && gnt_q == GW'(p)) begin
        o_ready[p] = slot_free && sel_en;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    vld_d   = xfer ? 1'b1 : (i_ready ? 1'b0 : vld_q);
    data_d  = xfer ? sel_d : data_q;
    port_d  = xfer ? NUM_PORT_BITS'(gnt_q) : port_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!sel_en) begin
          state_d = IDLE;
          rr_d    = gnt_nxt;
        end else if (xfer) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(MAX_BURST)) begin
            state_d = IDLE;
            rr_d    = gnt_nxt;
          end
        end else if (!sel_v && slot_free) begin
          // Source ran dry with room downstream: give others a turn.
          state_d = IDLE;
          rr_d    = gnt_nxt;
        end
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      port_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      port_q  <= port_d;
      vld_q   <= vld_d;
    end
  end

  assign o_data  = data_q;
  assign o_port  = port_q;
  assign o_valid = vld_q;
  assign o_busy  = (state_q == GRANT);

endmodule
